// File: rtl/uart_tx_queue.sv
// uart_tx_queue
// Buffered transmit front-end for a UART transmitter. A producer offers
// words with a single-cycle strobe. The words wait in a circular FIFO and
// are handed to the transmitter one at a time over a txStart/txBusy
// handshake.
//
// Ports
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   data_ready_i    write strobe, one word per high cycle
//   data_i          word to queue
//   clr_overflow_i  clears the sticky overflow flag
//   full_o          FIFO holds DEPTH words
//   almost_full_o   level >= AFULL_LVL
//   empty_o         FIFO holds no words
//   level_o         words stored, 0..DEPTH
//   overflow_o      sticky, set when a write is dropped because the FIFO is full
//   tx_busy_i       transmitter is shifting a word
//   tx_start_o      one-cycle start pulse to the transmitter
//   tx_data_o       word for the transmitter, held until the next pop
module uart_tx_queue #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_LVL = DEPTH - 2,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              data_ready_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              clr_overflow_i,
    output logic              full_o,
    output logic              almost_full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   level_o,
    output logic              overflow_o,
    input  logic              tx_busy_i,
    output logic              tx_start_o,
    output logic [DATA_W-1:0] tx_data_o
);

    localparam logic [ADDR_W:0]   LVL_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   LVL_FULL  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LVL_AFULL = (ADDR_W + 1)'(AFULL_LVL);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } state_e;

    // Storage has no reset so it can map onto block RAM.
    logic [DATA_W-1:0] mem_q [DEPTH];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wp_q, rp_q;
    logic [ADDR_W:0]   level_q, level_d;
    logic              full_q, afull_q, empty_q, overflow_q;
    logic              tx_start_q, tx_start_d;
    logic [DATA_W-1:0] tx_data_q;
    logic              push, drop, pop;

    // The registered full flag decides acceptance, so a pop in the same
    // cycle never makes room for a write offered while full.
    assign push = data_ready_i & ~full_q;
    assign drop = data_ready_i &  full_q;

    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_q && !tx_busy_i) begin
                    pop        = 1'b1;
                    tx_start_d = 1'b1;
                    state_d    = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (tx_busy_i) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wp_q       <= '0;
            rp_q       <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            level_q    <= level_d;
            // Flags come from the next level so they move on the same edge.
            full_q     <= (level_d == LVL_FULL);
            afull_q    <= (level_d >= LVL_AFULL);
            empty_q    <= (level_d == '0);
            if (push) begin
                wp_q <= wp_q + PTR_ONE;
            end
            if (pop) begin
                rp_q      <= rp_q + PTR_ONE;
                tx_data_q <= mem_q[rp_q];
            end
            // A dropped write outranks a clear in the same cycle.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clr_overflow_i) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign full_o        = full_q;
    assign almost_full_o = afull_q;
    assign empty_o       = empty_q;
    assign level_o       = level_q;
    assign overflow_o    = overflow_q;
    assign tx_start_o    = tx_start_q;
    assign tx_data_o     = tx_data_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Testbench for uart_tx_queue with DATA_W=8, DEPTH=16.
// The reference model holds the queue contents as a plain queue and tracks
// whether a transfer is outstanding on the handshake. Its prediction of the
// outputs is compared with the DUT at every falling edge. A small
// transmitter model answers txStart with a busy period and records the words
// it receives.
module tb_uart_tx_queue;

    localparam int DEPTH = 16;
    localparam int AFL   = DEPTH - 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       data_ready_i;
    logic [7:0] data_i;
    logic       clr_overflow_i;
    logic       full_o, almost_full_o, empty_o, overflow_o;
    logic [4:0] level_o;
    logic       tx_busy_i;
    logic       tx_start_o;
    logic [7:0] tx_data_o;

    logic hold_busy = 1'b0;
    logic xmit_busy = 1'b0;
    assign tx_busy_i = hold_busy | xmit_busy;

    uart_tx_queue dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_ready_i   (data_ready_i),
        .data_i         (data_i),
        .clr_overflow_i (clr_overflow_i),
        .full_o         (full_o),
        .almost_full_o  (almost_full_o),
        .empty_o        (empty_o),
        .level_o        (level_o),
        .overflow_o     (overflow_o),
        .tx_busy_i      (tx_busy_i),
        .tx_start_o     (tx_start_o),
        .tx_data_o      (tx_data_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ---------------- reference model ----------------
    byte unsigned m_q[$];
    byte unsigned m_acc[$];
    bit         m_ovf = 1'b0;
    bit         m_open = 1'b0;
    bit         m_seen = 1'b0;
    bit         m_start = 1'b0;
    logic [7:0] m_txd = 8'h00;
    bit         m_full_pre, m_empty_pre, m_pop;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                m_ovf   = 1'b0;
                m_open  = 1'b0;
                m_seen  = 1'b0;
                m_start = 1'b0;
                m_txd   = 8'h00;
            end else begin
                m_full_pre  = (m_q.size() == DEPTH);
                m_empty_pre = (m_q.size() == 0);
                // A word is handed over only when no transfer is outstanding
                // and the transmitter is not busy.
                m_pop   = !m_open && !m_empty_pre && !tx_busy_i;
                m_start = m_pop;
                if (m_pop) begin
                    m_txd  = m_q.pop_front();
                    m_open = 1'b1;
                    m_seen = 1'b0;
                end else if (m_open) begin
                    if (!m_seen) begin
                        if (tx_busy_i) m_seen = 1'b1;
                    end else if (!tx_busy_i) begin
                        m_open = 1'b0;
                    end
                end
                if (data_ready_i && m_full_pre) m_ovf = 1'b1;
                else if (clr_overflow_i)       m_ovf = 1'b0;
                if (data_ready_i && !m_full_pre) begin
                    m_q.push_back(data_i);
                    m_acc.push_back(data_i);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [17:0] cmp_act, cmp_exp;
    initial begin
        forever begin
            @(negedge clk);
            cmp_act = {full_o, almost_full_o, empty_o, level_o, overflow_o, tx_start_o, tx_data_o};
            cmp_exp = {m_q.size() == DEPTH, m_q.size() >= AFL, m_q.size() == 0,
                       5'(m_q.size()), m_ovf, m_start, m_txd};
            tests++;
            if (cmp_act !== cmp_exp) begin
                fails++;
                $display("FAIL model_cmp t=%0t got full=%b af=%b empty=%b level=%0d ovf=%b start=%b data=%02h expected full=%b af=%b empty=%b level=%0d ovf=%b start=%b data=%02h",
                         $time, cmp_act[17], cmp_act[16], cmp_act[15], cmp_act[14:10], cmp_act[9], cmp_act[8], cmp_act[7:0],
                         cmp_exp[17], cmp_exp[16], cmp_exp[15], cmp_exp[14:10], cmp_exp[9], cmp_exp[8], cmp_exp[7:0]);
            end
        end
    end

    // ---------------- transmitter model ----------------
    int tx_busy_len  = 20;   // 0 selects a random length of 1..4 cycles
    int tx_delay_max = 0;
    int start_count  = 0;
    int tx_d, tx_len;
    byte unsigned rx_q[$];

    initial begin
        forever begin
            @(negedge clk);
            if (tx_start_o === 1'b1) begin
                rx_q.push_back(tx_data_o);
                start_count++;
                tests++;
                if (tx_busy_i !== 1'b0) begin
                    fails++;
                    $display("FAIL start_while_busy t=%0t got busy=%b expected 0", $time, tx_busy_i);
                end
                $display("[TB] t=%0t txStart data=%02h", $time, tx_data_o);
                tx_d = $urandom_range(tx_delay_max, 0);
                repeat (tx_d) @(negedge clk);
                xmit_busy = 1'b1;
                tx_len = (tx_busy_len > 0) ? tx_busy_len : int'($urandom_range(4, 1));
                repeat (tx_len) @(negedge clk);
                xmit_busy = 1'b0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        data_ready_i = 1'b1;
        data_i       = d;
        step();
        data_ready_i = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int c = 0;
        while ((rx_q.size() < n || xmit_busy || m_open) && c < 5000) begin
            step();
            c++;
        end
        tests++;
        if (c >= 5000) begin
            fails++;
            $display("FAIL wait_timeout got %0d words expected %0d", rx_q.size(), n);
        end
        step();
        step();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_start"}, 32'(tx_start_o),    32'd0);
        check({tag, "_data"},  32'(tx_data_o),     32'd0);
        check({tag, "_level"}, 32'(level_o),       32'd0);
        check({tag, "_empty"}, 32'(empty_o),       32'd1);
        check({tag, "_full"},  32'(full_o),        32'd0);
        check({tag, "_afull"}, 32'(almost_full_o), 32'd0);
        check({tag, "_ovf"},   32'(overflow_o),    32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    byte unsigned w[6];
    int sc;
    int c5;

    initial begin
        rst_n          = 1'b0;
        data_ready_i   = 1'b0;
        data_i         = 8'h00;
        clr_overflow_i = 1'b0;
        repeat (2) step();
        check_reset_values("reset");
        rst_n = 1'b1;
        repeat (10) begin
            step();
            check("idle_start", 32'(tx_start_o), 32'd0);
        end
        check("idle_empty", 32'(empty_o), 32'd1);
        check("idle_level", 32'(level_o), 32'd0);
        check("idle_count", 32'(start_count), 32'd0);

        // Single word
        tx_busy_len = 20;
        rx_q.delete();
        push(8'hA5);
        check("single_level1", 32'(level_o), 32'd1);
        check("single_empty", 32'(empty_o), 32'd0);
        check("single_nostart", 32'(tx_start_o), 32'd0);
        step();
        check("single_start", 32'(tx_start_o), 32'd1);
        check("single_data", 32'(tx_data_o), 32'hA5);
        check("single_level0", 32'(level_o), 32'd0);
        step();
        check("single_pulse_end", 32'(tx_start_o), 32'd0);
        wait_done(1);
        check("single_rx_n", 32'(rx_q.size()), 32'd1);
        check("single_rx", 32'(rx_q[0]), 32'hA5);

        // Burst fill with the transmitter held busy, then overflow
        rx_q.delete();
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            check("burst_level", 32'(level_o), 32'(i + 1));
            check("burst_afull", 32'(almost_full_o), 32'(i + 1 >= 14));
            check("burst_full", 32'(full_o), 32'(i + 1 == 16));
        end
        push(8'hFF);
        check("ovf_level", 32'(level_o), 32'd16);
        check("ovf_set", 32'(overflow_o), 32'd1);
        step();
        check("ovf_sticky", 32'(overflow_o), 32'd1);
        clr_overflow_i = 1'b1;
        step();
        clr_overflow_i = 1'b0;
        check("ovf_clear", 32'(overflow_o), 32'd0);
        data_ready_i   = 1'b1;
        data_i         = 8'hFF;
        clr_overflow_i = 1'b1;
        step();
        data_ready_i   = 1'b0;
        clr_overflow_i = 1'b0;
        check("ovf_set_wins", 32'(overflow_o), 32'd1);
        check("ovf_level2", 32'(level_o), 32'd16);
        clr_overflow_i = 1'b1;
        step();
        clr_overflow_i = 1'b0;
        hold_busy = 1'b0;
        wait_done(16);
        check("burst_rx_n", 32'(rx_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
            check("burst_order", 32'(rx_q[i]), 32'(i));
        end

        // Simultaneous push and pop at level 5
        rx_q.delete();
        tx_busy_len = 3;
        hold_busy   = 1'b1;
        for (int i = 0; i < 6; i++) w[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) push(w[i]);
        check("pp_level_before", 32'(level_o), 32'd5);
        hold_busy    = 1'b0;
        data_ready_i = 1'b1;
        data_i       = w[5];
        step();
        data_ready_i = 1'b0;
        check("pp_level_after", 32'(level_o), 32'd5);
        check("pp_start", 32'(tx_start_o), 32'd1);
        check("pp_data", 32'(tx_data_o), 32'(w[0]));
        wait_done(6);
        check("pp_rx_n", 32'(rx_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
            check("pp_order", 32'(rx_q[i]), 32'(w[i]));
        end

        // Pointer wrap: 40 random words with random gaps and busy times
        rx_q.delete();
        m_acc.delete();
        tx_busy_len  = 0;
        tx_delay_max = 2;
        c5 = 0;
        while (m_acc.size() < 40 && c5 < 3000) begin
            data_ready_i = 1'($urandom_range(1, 0));
            data_i       = 8'($urandom);
            step();
            c5++;
        end
        data_ready_i = 1'b0;
        check("wrap_accepted", 32'(m_acc.size()), 32'd40);
        wait_done(m_acc.size());
        check("wrap_rx_n", 32'(rx_q.size()), 32'(m_acc.size()));
        for (int i = 0; i < rx_q.size() && i < m_acc.size(); i++) begin
            check("wrap_order", 32'(rx_q[i]), 32'(m_acc[i]));
        end
        clr_overflow_i = 1'b1;
        step();
        clr_overflow_i = 1'b0;

        // Reset while the transmitter is busy with 7 words queued
        tx_busy_len  = 30;
        tx_delay_max = 0;
        for (int i = 0; i < 8; i++) begin
            data_ready_i = 1'b1;
            data_i       = 8'(8'h31 + i);
            step();
        end
        data_ready_i = 1'b0;
        repeat (3) step();
        check("mid_level", 32'(level_o), 32'd7);
        check("mid_busy", 32'(tx_busy_i), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        sc = start_count;
        step();
        step();
        rst_n = 1'b1;
        repeat (50) step();
        check("post_reset_nostart", 32'(start_count), 32'(sc));
        check("post_reset_empty", 32'(empty_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Parametrised, buffered transmit front-end for the UART transmitter. Accepts words from a producer on a single-cycle strobe, queues them in an internal circular FIFO, and feeds them one at a time to the UART transmitter over its txStart/txBusy handshake. Reports full, almost-full, empty, fill level and a sticky overflow flag back to the producer. Sits between application logic and the UART transmitter core.

## Interface
- DATA_W, 8, width of each queued word and of txData
- DEPTH, 16, FIFO capacity in words; power of two, at least 2
- ADDR_W, log2(DEPTH), pointer width; derived, never overridden
- AFULL_LVL, DEPTH-2, level at or above which almostFull asserts
- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-low reset
- dataReady  in  1  write strobe; one word is offered per high cycle
- data  in  DATA_W  word to queue, sampled when dataReady is high
- clrOverflow  in  1  synchronous clear of the overflow flag
- full  out  1  FIFO holds DEPTH words
- almostFull  out  1  level >= AFULL_LVL
- empty  out  1  FIFO holds no words
- level  out  ADDR_W+1  number of words currently stored, 0..DEPTH
- overflow  out  1  sticky; set when a write is dropped
- txBusy  in  1  transmitter is busy shifting a word
- txStart  out  1  one-cycle start pulse to the transmitter
- txData  out  DATA_W  word for the transmitter; valid from the txStart cycle until txBusy falls

## Operation
- Storage: DEPTH x DATA_W array, write pointer wp, read pointer rp, both ADDR_W bits, wrap modulo DEPTH naturally. level is a separate ADDR_W+1 counter.
- Push: accepted at an edge when dataReady=1 and full=0; mem[wp]<=data, wp<=wp+1.
- Dropped push: dataReady=1 and full=1; storage untouched, overflow<=1. A simultaneous pop does not make room for it: the full value sampled before the edge decides.
- Overflow: set wins over clrOverflow in the same cycle; otherwise clrOverflow=1 clears it.
- Pop: occurs only on the IDLE->WAIT_BUSY transition; rp<=rp+1.
- level: +1 on push only, -1 on pop only, unchanged on both or neither. full=(level==DEPTH), empty=(level==0), almostFull=(level>=AFULL_LVL). All flags are registered and update on the same edge as level.
- Transmit FSM, three states:
  - IDLE: txStart=0. If empty=0 and txBusy=0: txData<=mem[rp], txStart<=1, pop, go to WAIT_BUSY.
  - WAIT_BUSY: txStart<=0 after one cycle. Stay until txBusy=1, then go to WAIT_DONE.
  - WAIT_DONE: stay until txBusy=0, then go to IDLE.
- txData holds its value until the next pop.
- Reset, asynchronous and valid at any time including mid-transfer: state=IDLE, wp=rp=0, level=0, empty=1, full=0, almostFull=0 (AFULL_LVL>0), overflow=0, txStart=0, txData=0. Queued words are discarded. A transmitter already running finishes on its own.

## Timing
- Push to visibility: a word written at edge N clears empty and updates level after edge N.
- Empty queue, idle transmitter: dataReady high in the cycle before edge N gives txStart high in the cycle after edge N+1. The latency is one cycle.
- txStart is high for exactly one cycle per popped word and never while txBusy=1 is sampled in IDLE.
- The transmitter must raise txBusy within a finite time after txStart. The FSM waits in WAIT_BUSY indefinitely.
- Best-case throughput is one word per (transmitter busy time + 2) cycles.
- Back-to-back dataReady at full rate is supported until full is reached.

## Test plan
- Reset with DATA_W=8, DEPTH=16: all outputs at their reset values. Release rst, hold dataReady low for 10 cycles: txStart stays 0, empty=1, level=0.
- Single word: push 0xA5 with the transmitter model busy for 20 cycles after each start. txStart pulses once for 1 cycle, one cycle after the write, with txData=0xA5. level goes 1 then 0.
- Burst ordering: push 0x00..0x0F back-to-back. full=1 after the 16th write, almostFull=1 from level 14. Transmitted sequence is exactly 0x00..0x0F. Exactly one txStart per txBusy period.
- Overflow: while full, push 0xFF. Word is dropped, level stays 16, overflow=1 and stays set. Pulse clrOverflow to clear it. Assert clrOverflow together with a dropped push: overflow stays 1.
- Simultaneous push/pop at level 5: level stays 5 and both words are preserved in order. Pointer wrap: run 40 words through DEPTH=16 and check ordering across the wrap.
- Reset mid-operation: assert rst while in WAIT_DONE with 7 words queued. All outputs return to reset values immediately. After release, no txStart occurs until a new push.
